// File: rtl/rgb_pwm_driver_if.sv
// Duty-update handshake between the colour-cycle generator (master) and the
// RGB PWM driver (slave): one r/g/b duty triple per valid/ready transfer.
interface rgb_pwm_driver_if #(
   parameter int W = 11
);
   logic [W-1:0] r_pwm_in;
   logic [W-1:0] g_pwm_in;
   logic [W-1:0] b_pwm_in;
   logic         duty_valid;
   logic         duty_ready;

   modport master (
      output r_pwm_in, g_pwm_in, b_pwm_in, duty_valid,
      input  duty_ready
   );

   modport slave (
      input  r_pwm_in, g_pwm_in, b_pwm_in, duty_valid,
      output duty_ready
   );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver. Duty triples land in a shadow register and are
// committed only at a period boundary, so every period uses one consistent triple.
module rgb_pwm_driver #(
   parameter int PWM_INTERVAL = 1200,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int W            = $clog2(PWM_INTERVAL)
) (
   input  logic            clk,
   input  logic            rst_n,
   rgb_pwm_driver_if.slave duty_if,
   output logic            red,
   output logic            green,
   output logic            blue,
   output logic            period_start
);

   localparam logic [W-1:0] DUTY_MAX = W'(PWM_INTERVAL);
   localparam logic [W-1:0] CNT_LAST = W'(PWM_INTERVAL - 1);
   localparam logic         PIN_OFF  = ACTIVE_LOW;

   // Channel index 0 = red, 1 = green, 2 = blue.
   typedef logic [2:0][W-1:0] duty_t;

   function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] v);
      return (v > DUTY_MAX) ? DUTY_MAX : v;
   endfunction

   logic [W-1:0] counter_q, counter_d;
   duty_t        active_q, active_d;
   duty_t        shadow_q, shadow_d;
   logic         pending_q, pending_d;
   logic [2:0]   pins_q, pins_d;
   logic         period_start_q, period_start_d;

   logic wrap;
   logic xfer;

   assign wrap = (counter_q == CNT_LAST);
   assign xfer = duty_if.duty_valid && !pending_q;

   assign duty_if.duty_ready = !pending_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      counter_d      = wrap ? '0 : counter_q + 1'b1;
      active_d       = active_q;
      shadow_d       = shadow_q;
      pending_d      = pending_q;
      period_start_d = (counter_q == '0);
      pins_d         = {3{PIN_OFF}};

      // A triple accepted in the wrap cycle waits a full period: commit only
      // looks at the pending flag as it stood before this edge.
      if (wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      if (xfer) begin
         shadow_d[0] = clamp_duty(duty_if.r_pwm_in);
         shadow_d[1] = clamp_duty(duty_if.g_pwm_in);
         shadow_d[2] = clamp_duty(duty_if.b_pwm_in);
         pending_d   = 1'b1;
      end

      for (int i = 0; i < 3; i++) begin
         pins_d[i] = (counter_q < active_q[i]) ^ PIN_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shadow triple is reset along with the pending flag so no
         // stale duty can ever be committed after a reset.
         counter_q      <= '0;
         active_q       <= '0;
         shadow_q       <= '0;
         pending_q      <= 1'b0;
         pins_q         <= {3{PIN_OFF}};
         period_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         counter_q      <= counter_d;
         active_q       <= active_d;
         shadow_q       <= shadow_d;
         pending_q      <= pending_d;
         pins_q         <= pins_d;
         period_start_q <= period_start_d;
      end
   end

   assign red          = pins_q[0];
   assign green        = pins_q[1];
   assign blue         = pins_q[2];
   assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a period-level schedule model (which period each
// accepted triple belongs to) predicts ready, period_start and the three pins.
module tb_rgb_pwm_driver;

   localparam int N  = 12;
   localparam int WS = 4;
   localparam int NB = 1200;
   localparam int WB = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rgb_pwm_driver_if #(.W(WS)) dif ();
   rgb_pwm_driver_if #(.W(WS)) iif ();
   rgb_pwm_driver_if #(.W(WB)) bif ();

   logic red, green, blue, ps;
   logic red_i, green_i, blue_i, ps_i;
   logic red_b, green_b, blue_b, ps_b;

   rgb_pwm_driver #(.PWM_INTERVAL(N), .ACTIVE_LOW(1'b1), .W(WS)) u_dut (
      .clk(clk), .rst_n(rst_n), .duty_if(dif),
      .red(red), .green(green), .blue(blue), .period_start(ps)
   );

   rgb_pwm_driver #(.PWM_INTERVAL(N), .ACTIVE_LOW(1'b0), .W(WS)) u_inv (
      .clk(clk), .rst_n(rst_n), .duty_if(iif),
      .red(red_i), .green(green_i), .blue(blue_i), .period_start(ps_i)
   );

   rgb_pwm_driver #(.PWM_INTERVAL(NB), .ACTIVE_LOW(1'b1), .W(WB)) u_big (
      .clk(clk), .rst_n(rst_n), .duty_if(bif),
      .red(red_b), .green(green_b), .blue(blue_b), .period_start(ps_b)
   );

   // The inverted-polarity instance sees exactly the same source as the main one.
   assign iif.r_pwm_in   = dif.r_pwm_in;
   assign iif.g_pwm_in   = dif.g_pwm_in;
   assign iif.b_pwm_in   = dif.b_pwm_in;
   assign iif.duty_valid = dif.duty_valid;

   int n_vec = 0;
   int n_err = 0;

   // Schedule model: k = clock edges since reset release. After edge k the pins
   // show phase (k-1)%N of period (k-1)/N. A triple accepted at edge k is shown
   // from period (k-1)/N+1, or one later if edge k closed a period (k%N==0);
   // the driver stays busy until the edge that closes the period before that.
   int   k;
   int   cur [3];
   int   nxt [3];
   bit   have_nxt;
   int   nxt_period;
   bit   m_pend;
   int   pend_until;
   bit   last_xfer;
   logic [4:0] exp_v;

   function automatic int clampi(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [4:0] main_vec();
      return {dif.duty_ready, ps, red, green, blue};
   endfunction

   function automatic logic [4:0] inv_vec();
      return {iif.duty_ready, ps_i, ~red_i, ~green_i, ~blue_i};
   endfunction

   task automatic model_reset();
      k        = 0;
      m_pend   = 1'b0;
      have_nxt = 1'b0;
      for (int c = 0; c < 3; c++) cur[c] = 0;
   endtask

   task automatic tick();
      bit xfer;
      int p;
      int per;
      xfer = dif.duty_valid && !m_pend;
      @(posedge clk);
      k++;
      p   = (k - 1) % N;
      per = (k - 1) / N;
      if (m_pend && k == pend_until) m_pend = 1'b0;
      if (have_nxt && per >= nxt_period) begin
         cur      = nxt;
         have_nxt = 1'b0;
      end
      if (xfer) begin
         nxt[0]     = clampi(int'(dif.r_pwm_in), N);
         nxt[1]     = clampi(int'(dif.g_pwm_in), N);
         nxt[2]     = clampi(int'(dif.b_pwm_in), N);
         nxt_period = (k % N == 0) ? per + 2 : per + 1;
         pend_until = nxt_period * N;
         m_pend     = 1'b1;
         have_nxt   = 1'b1;
      end
      last_xfer = xfer;
      exp_v[4]  = !m_pend;
      exp_v[3]  = (p == 0);
      for (int c = 0; c < 3; c++) exp_v[2-c] = !(p < cur[c]);
      @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      dif.duty_valid = 1'b0;
      bif.duty_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (main_vec() !== 5'b10111) begin
         n_err++; $display("FAIL reset_main got %b want %b", main_vec(), 5'b10111);
      end
      n_vec++;
      if (inv_vec() !== 5'b10111) begin
         n_err++; $display("FAIL reset_inv got %b want %b", inv_vec(), 5'b10111);
      end
      n_vec++;
      if ({bif.duty_ready, ps_b, red_b, green_b, blue_b} !== 5'b10111) begin
         n_err++; $display("FAIL reset_big got %b want %b", {bif.duty_ready, ps_b, red_b, green_b, blue_b}, 5'b10111);
      end
      release_reset();
      repeat (3 * N + 2) begin
         tick();
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL idle k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
         n_vec++;
         if (inv_vec() !== exp_v) begin
            n_err++; $display("FAIL idle k=%0d inv got %b want %b", k, inv_vec(), exp_v);
         end
      end
   endtask

   task automatic test_load();
      int guard = 0;
      while (k % N != 4 && guard < 2 * N) begin
         tick(); guard++;
      end
      dif.r_pwm_in = 4'd3; dif.g_pwm_in = 4'd12; dif.b_pwm_in = 4'd0;
      dif.duty_valid = 1'b1;
      repeat (3 * N) begin
         tick();
         if (last_xfer) dif.duty_valid = 1'b0;
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL load k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
         n_vec++;
         if (inv_vec() !== exp_v) begin
            n_err++; $display("FAIL load k=%0d inv got %b want %b", k, inv_vec(), exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 2; t++) begin
         int guard = 0;
         dif.r_pwm_in   = (t == 0) ? 4'd2 : 4'd6;
         dif.g_pwm_in   = WS'($urandom_range(0, 15));
         dif.b_pwm_in   = WS'($urandom_range(0, 15));
         dif.duty_valid = 1'b1;
         do begin
            tick(); guard++;
            n_vec++;
            if (main_vec() !== exp_v) begin
               n_err++; $display("FAIL b2b k=%0d main got %b want %b", k, main_vec(), exp_v);
            end
            n_vec++;
            if (inv_vec() !== exp_v) begin
               n_err++; $display("FAIL b2b k=%0d inv got %b want %b", k, inv_vec(), exp_v);
            end
         end while (!last_xfer && guard < 3 * N);
         dif.duty_valid = 1'b0;
      end
      repeat (3 * N) begin
         tick();
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL b2b_drain k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
      end
   endtask

   task automatic test_wrap_handshake();
      int guard = 0;
      while ((m_pend || k % N != N - 1) && guard < 3 * N) begin
         tick(); guard++;
      end
      dif.r_pwm_in   = 4'd5;
      dif.g_pwm_in   = WS'($urandom_range(0, 15));
      dif.b_pwm_in   = WS'($urandom_range(0, 15));
      dif.duty_valid = 1'b1;
      repeat (3 * N + 1) begin
         tick();
         if (last_xfer) dif.duty_valid = 1'b0;
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL wrap_hs k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
         n_vec++;
         if (inv_vec() !== exp_v) begin
            n_err++; $display("FAIL wrap_hs k=%0d inv got %b want %b", k, inv_vec(), exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while ((m_pend || k % N != 1) && guard < 3 * N) begin
         tick(); guard++;
      end
      dif.r_pwm_in = 4'd9; dif.g_pwm_in = 4'd4; dif.b_pwm_in = 4'd7;
      dif.duty_valid = 1'b1;
      repeat (2) begin
         tick();
         if (last_xfer) dif.duty_valid = 1'b0;
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL pre_rst k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (main_vec() !== 5'b10111) begin
         n_err++; $display("FAIL rst_mid_main got %b want %b", main_vec(), 5'b10111);
      end
      n_vec++;
      if (inv_vec() !== 5'b10111) begin
         n_err++; $display("FAIL rst_mid_inv got %b want %b", inv_vec(), 5'b10111);
      end
      @(negedge clk);
      release_reset();
      repeat (3 * N + 2) begin
         tick();
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL post_rst k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
         n_vec++;
         if (inv_vec() !== exp_v) begin
            n_err++; $display("FAIL post_rst k=%0d inv got %b want %b", k, inv_vec(), exp_v);
         end
      end
   endtask

   task automatic test_clamp();
      int g_req, b_req;
      int lit_r = 0, lit_g = 0, lit_b = 0, ps_cnt = 0;
      @(negedge clk);
      rst_n = 1'b0;
      dif.duty_valid = 1'b0;
      bif.duty_valid = 1'b0;
      @(negedge clk);
      release_reset();
      g_req = int'($urandom_range(0, 2047));
      b_req = int'($urandom_range(0, 2047));
      bif.r_pwm_in   = 11'd2000;
      bif.g_pwm_in   = WB'(g_req);
      bif.b_pwm_in   = WB'(b_req);
      bif.duty_valid = 1'b1;
      tick();
      bif.duty_valid = 1'b0;
      n_vec++;
      if (bif.duty_ready !== 1'b0) begin
         n_err++; $display("FAIL clamp_ready_low got %b want 0", bif.duty_ready);
      end
      repeat (2 * NB - 1) begin
         tick();
         if (k == NB - 1 || k == NB) begin
            n_vec++;
            if (bif.duty_ready !== (k == NB)) begin
               n_err++; $display("FAIL clamp_ready k=%0d got %b want %b", k, bif.duty_ready, (k == NB));
            end
         end
         if (k > NB) begin
            lit_r  += int'(!red_b);
            lit_g  += int'(!green_b);
            lit_b  += int'(!blue_b);
            ps_cnt += int'(ps_b);
         end
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL clamp_idle k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
      end
      n_vec++;
      if (lit_r !== NB) begin
         n_err++; $display("FAIL clamp_red lit=%0d want %0d", lit_r, NB);
      end
      n_vec++;
      if (lit_g !== clampi(g_req, NB)) begin
         n_err++; $display("FAIL clamp_green lit=%0d want %0d", lit_g, clampi(g_req, NB));
      end
      n_vec++;
      if (lit_b !== clampi(b_req, NB)) begin
         n_err++; $display("FAIL clamp_blue lit=%0d want %0d", lit_b, clampi(b_req, NB));
      end
      n_vec++;
      if (ps_cnt !== 1) begin
         n_err++; $display("FAIL clamp_period_start count=%0d want 1", ps_cnt);
      end
   endtask

   task automatic test_random();
      repeat (30 * N) begin
         if (!dif.duty_valid && $urandom_range(0, 3) == 0) begin
            dif.r_pwm_in   = WS'($urandom_range(0, 15));
            dif.g_pwm_in   = WS'($urandom_range(0, 15));
            dif.b_pwm_in   = WS'($urandom_range(0, 15));
            dif.duty_valid = 1'b1;
         end
         tick();
         if (last_xfer) dif.duty_valid = 1'b0;
         n_vec++;
         if (main_vec() !== exp_v) begin
            n_err++; $display("FAIL random k=%0d main got %b want %b", k, main_vec(), exp_v);
         end
         n_vec++;
         if (inv_vec() !== exp_v) begin
            n_err++; $display("FAIL random k=%0d inv got %b want %b", k, inv_vec(), exp_v);
         end
      end
      dif.duty_valid = 1'b0;
   endtask

   initial begin
      dif.r_pwm_in = '0; dif.g_pwm_in = '0; dif.b_pwm_in = '0; dif.duty_valid = 1'b0;
      bif.r_pwm_in = '0; bif.g_pwm_in = '0; bif.b_pwm_in = '0; bif.duty_valid = 1'b0;
      model_reset();
      test_reset();
      test_load();
      test_back_to_back();
      test_wrap_handshake();
      test_reset_mid();
      test_random();
      test_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
